// File: rtl/approx_restoring_divider_pkg.sv
// Shared definitions for the approximate restoring divider.
// Holds the controller state encoding and the default operand widths and
// approximation depth used by the top level and the step datapath.
package approx_restoring_divider_pkg;

   localparam int unsigned DEF_A_W      = 8;
   localparam int unsigned DEF_B_W      = 6;
   localparam int unsigned DEF_APPROX_K = 0;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_e;

endpackage : approx_restoring_divider_pkg

// File: rtl/approx_restoring_divider_div_step.sv
// One restoring-division iteration: compare-subtract of the pre-shifted divisor.
// Ports:
//   rem        current partial remainder
//   dsh        divisor already aligned to the bit being retired
//   rem_next_c partial remainder after this iteration (combinational)
//   q_bit_c    retired quotient bit (combinational)
module div_step
   import approx_restoring_divider_pkg::*;
#(
   parameter int unsigned W = DEF_A_W + DEF_B_W
) (
   input  logic [W-1:0] rem,
   input  logic [W-1:0] dsh,
   output logic [W-1:0] rem_next_c,
   output logic         q_bit_c
);

   logic [W:0] diff_c;

   // Extra MSB acts as the borrow: set means the trial went negative.
   always_comb begin
      diff_c     = {1'b0, rem} - {1'b0, dsh};
      q_bit_c    = ~diff_c[W];
      rem_next_c = q_bit_c ? diff_c[W-1:0] : rem;
   end

endmodule : div_step

// File: rtl/approx_restoring_divider.sv
// Multi-cycle restoring divider with optional approximation of quotient LSBs.
// Divides an (A_W+B_W)-bit dividend by a B_W-bit divisor, one quotient bit per
// cycle MSB first; the lowest APPROX_K iterations are skipped and those bits
// are forced to one. Divide-by-zero and quotient overflow finish in one cycle.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   operand handshake (ready only while idle)
//   dividend, divisor     operands, captured on acceptance
//   out_valid / out_ready result handshake (valid only while done)
//   quotient, remainder   result
//   div_by_zero, overflow status flags for the result
module approx_restoring_divider
   import approx_restoring_divider_pkg::*;
#(
   parameter int unsigned A_W      = DEF_A_W,
   parameter int unsigned B_W      = DEF_B_W,
   parameter int unsigned APPROX_K = DEF_APPROX_K
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [A_W+B_W-1:0] dividend,
   input  logic [B_W-1:0]     divisor,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [A_W-1:0]     quotient,
   output logic [B_W-1:0]     remainder,
   output logic               div_by_zero,
   output logic               overflow
);

   localparam int unsigned      P_W       = A_W + B_W;
   localparam int unsigned      CNT_W     = (A_W > 1) ? $clog2(A_W) : 1;
   localparam logic [A_W-1:0]   LOW_MASK  = ~({A_W{1'b1}} << APPROX_K);
   localparam logic [CNT_W-1:0] FIRST_IDX = CNT_W'(A_W - 1);
   localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(APPROX_K);

   state_e           state, state_next;
   logic [P_W-1:0]   rem, rem_next;
   logic [P_W-1:0]   dsh, dsh_next;
   logic [A_W-1:0]   acc, acc_next;
   logic [CNT_W-1:0] idx, idx_next;
   logic [A_W-1:0]   quotient_next;
   logic [B_W-1:0]   remainder_next;
   logic             div_by_zero_next;
   logic             overflow_next;
   logic             in_ready_next;
   logic             out_valid_next;
   logic [P_W-1:0]   step_rem_c;
   logic             step_bit_c;

   div_step #(
      .W (P_W)
   ) u_div_step (
      .rem        (rem),
      .dsh        (dsh),
      .rem_next_c (step_rem_c),
      .q_bit_c    (step_bit_c)
   );

   // State and datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         rem         <= '0;
         dsh         <= '0;
         acc         <= '0;
         idx         <= '0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
         overflow    <= 1'b0;
         in_ready    <= 1'b1;
         out_valid   <= 1'b0;
      end else begin
         state       <= state_next;
         rem         <= rem_next;
         dsh         <= dsh_next;
         acc         <= acc_next;
         idx         <= idx_next;
         quotient    <= quotient_next;
         remainder   <= remainder_next;
         div_by_zero <= div_by_zero_next;
         overflow    <= overflow_next;
         in_ready    <= in_ready_next;
         out_valid   <= out_valid_next;
      end
   end

   // Next-state and next-output logic.
   always_comb begin
      state_next       = state;
      rem_next         = rem;
      dsh_next         = dsh;
      acc_next         = acc;
      idx_next         = idx;
      quotient_next    = quotient;
      remainder_next   = remainder;
      div_by_zero_next = div_by_zero;
      overflow_next    = overflow;

      case (state)
         IDLE: begin
            if (in_valid) begin
               quotient_next    = '0;
               remainder_next   = '0;
               div_by_zero_next = 1'b0;
               overflow_next    = 1'b0;
               rem_next         = dividend;
               dsh_next         = P_W'(divisor) << (A_W - 1);
               acc_next         = '0;
               idx_next         = FIRST_IDX;
               if (divisor == '0) begin
                  state_next       = DONE;
                  quotient_next    = '1;
                  remainder_next   = dividend[B_W-1:0];
                  div_by_zero_next = 1'b1;
               end else if (dividend[P_W-1:A_W] >= divisor) begin
                  // Quotient would need more than A_W bits.
                  state_next     = DONE;
                  quotient_next  = '1;
                  remainder_next = '1;
                  overflow_next  = 1'b1;
               end else begin
                  state_next = CALC;
               end
            end
         end

         CALC: begin
            rem_next = step_rem_c;
            dsh_next = dsh >> 1;
            acc_next = (acc << 1) | A_W'(step_bit_c);
            idx_next = idx - CNT_W'(1);
            if (idx == LAST_IDX) begin
               // Skipped LSB iterations are reported as ones; the remainder is
               // only meaningful when every bit was computed.
               state_next     = DONE;
               quotient_next  = (acc_next << APPROX_K) | LOW_MASK;
               remainder_next = (APPROX_K == 0) ? B_W'(step_rem_c) : '1;
            end
         end

         DONE: begin
            if (out_ready) begin
               state_next = IDLE;
            end
         end

         default: begin
            state_next = IDLE;
         end
      endcase

      in_ready_next  = (state_next == IDLE);
      out_valid_next = (state_next == DONE);
   end

endmodule : approx_restoring_divider

// File: tb/tb_approx_restoring_divider.sv
// Directed and sampled-random bench for approx_restoring_divider.
// Two instances: K=0 (exact) and K=3 (three quotient LSBs approximated).
module tb_approx_restoring_divider;

   localparam int unsigned A_W = 8;
   localparam int unsigned B_W = 6;
   localparam int unsigned P_W = A_W + B_W;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic           vld0 = 1'b0, vld3 = 1'b0;
   logic           rdy0, rdy3;
   logic           oval0, oval3;
   logic           out_ready = 1'b0;
   logic [P_W-1:0] dividend = '0;
   logic [B_W-1:0] divisor = '0;
   logic [A_W-1:0] q0, q3;
   logic [B_W-1:0] r0, r3;
   logic           dz0, dz3, of0, of3;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   approx_restoring_divider #(.A_W(A_W), .B_W(B_W), .APPROX_K(0)) dut0 (
      .clk(clk), .rst_n(rst_n), .in_valid(vld0), .in_ready(rdy0),
      .dividend(dividend), .divisor(divisor), .out_valid(oval0),
      .out_ready(out_ready), .quotient(q0), .remainder(r0),
      .div_by_zero(dz0), .overflow(of0)
   );

   approx_restoring_divider #(.A_W(A_W), .B_W(B_W), .APPROX_K(3)) dut3 (
      .clk(clk), .rst_n(rst_n), .in_valid(vld3), .in_ready(rdy3),
      .dividend(dividend), .divisor(divisor), .out_valid(oval3),
      .out_ready(out_ready), .quotient(q3), .remainder(r3),
      .div_by_zero(dz3), .overflow(of3)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] pick(input int which, input logic [31:0] a, input logic [31:0] b);
      return (which == 0) ? a : b;
   endfunction

   // One transaction. exp_lat counts edges after the acceptance edge until
   // out_valid is seen; 0 means valid straight off the acceptance edge.
   task automatic do_op(input string tag, input int which, input int dd, input int dv,
                        input int hold, input int exp_q, input int exp_r,
                        input int exp_dz, input int exp_ov, input int exp_lat);
      int lat;
      @(negedge clk);
      dividend = P_W'(dd);
      divisor  = B_W'(dv);
      if (which == 0) vld0 = 1'b1; else vld3 = 1'b1;
      @(posedge clk); #1;
      vld0 = 1'b0;
      vld3 = 1'b0;
      dividend = ~dividend;
      divisor  = ~divisor;
      if (exp_lat > 0) begin
         check_eq({tag, "_clr_q"}, pick(which, 32'(q0), 32'(q3)), 0);
         check_eq({tag, "_clr_r"}, pick(which, 32'(r0), 32'(r3)), 0);
         check_eq({tag, "_busy"}, pick(which, 32'(rdy0), 32'(rdy3)), 0);
      end
      lat = 0;
      while (pick(which, 32'(oval0), 32'(oval3)) == 0 && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      check_eq({tag, "_lat"}, lat, exp_lat);
      check_eq({tag, "_q"}, pick(which, 32'(q0), 32'(q3)), exp_q);
      check_eq({tag, "_r"}, pick(which, 32'(r0), 32'(r3)), exp_r);
      check_eq({tag, "_dz"}, pick(which, 32'(dz0), 32'(dz3)), exp_dz);
      check_eq({tag, "_ov"}, pick(which, 32'(of0), 32'(of3)), exp_ov);
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         check_eq({tag, "_hold_v"}, pick(which, 32'(oval0), 32'(oval3)), 1);
         check_eq({tag, "_hold_q"}, pick(which, 32'(q0), 32'(q3)), exp_q);
         check_eq({tag, "_hold_r"}, pick(which, 32'(r0), 32'(r3)), exp_r);
      end
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check_eq({tag, "_rel_v"}, pick(which, 32'(oval0), 32'(oval3)), 0);
      check_eq({tag, "_rel_rdy"}, pick(which, 32'(rdy0), 32'(rdy3)), 1);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog got timeout expected finish");
      $fatal(1);
   end

   initial begin
      int dd, dv, seen;

      repeat (3) @(posedge clk);
      #1;
      check_eq("rst_v0", 32'(oval0), 0);
      check_eq("rst_rdy0", 32'(rdy0), 1);
      check_eq("rst_q0", 32'(q0), 0);
      check_eq("rst_r0", 32'(r0), 0);
      check_eq("rst_f0", 32'({dz0, of0}), 0);
      check_eq("rst_v3", 32'(oval3), 0);
      check_eq("rst_q3", 32'(q3), 0);
      check_eq("rst_f3", 32'({dz3, of3}), 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      check_eq("post_rst_rdy0", 32'(rdy0), 1);
      check_eq("post_rst_rdy3", 32'(rdy3), 1);

      // Exact division with a long stall on the result.
      do_op("k0_1000_7", 0, 1000, 7, 10, 142, 6, 0, 0, 8);
      do_op("k0_div0", 0, 100, 0, 0, 255, 36, 1, 0, 0);
      do_op("k0_ovf", 0, 16383, 1, 0, 255, 63, 0, 1, 0);
      do_op("k0_after_ovf", 0, 5, 5, 0, 1, 0, 0, 0, 8);
      do_op("k0_zero", 0, 0, 5, 0, 0, 0, 0, 0, 8);
      do_op("k0_qmax", 0, 16127, 63, 0, 255, 62, 0, 0, 8);
      do_op("k0_ovf_edge", 0, 16128, 63, 0, 255, 63, 0, 1, 0);
      do_op("k0_div0_zero", 0, 0, 0, 0, 255, 0, 1, 0, 0);

      // Approximate instance.
      do_op("k3_1000_7", 1, 1000, 7, 3, 143, 63, 0, 0, 5);
      do_op("k3_2000_9", 1, 2000, 9, 0, 223, 63, 0, 0, 5);
      do_op("k3_zero", 1, 0, 1, 0, 7, 63, 0, 0, 5);
      do_op("k3_div0", 1, 100, 0, 0, 255, 36, 1, 0, 0);
      do_op("k3_ovf", 1, 16383, 1, 0, 255, 63, 0, 1, 0);

      // Reset in the middle of a calculation aborts it.
      @(negedge clk);
      dividend = P_W'(1000);
      divisor  = B_W'(7);
      vld0 = 1'b1;
      @(posedge clk); #1;
      vld0 = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check_eq("abort_rst_v", 32'(oval0), 0);
      check_eq("abort_rst_q", 32'(q0), 0);
      @(negedge clk);
      rst_n = 1'b1;
      seen = 0;
      repeat (15) begin
         @(posedge clk); #1;
         if (oval0) seen = 1;
      end
      check_eq("abort_never_valid", seen, 0);
      check_eq("abort_rdy", 32'(rdy0), 1);
      do_op("k0_recover", 0, 1000, 7, 0, 142, 6, 0, 0, 8);

      // Sampled random pairs restricted to the non-overflow range.
      for (int n = 0; n < 150; n++) begin
         dv = int'($urandom_range(1, 63));
         dd = int'($urandom_range(0, 32'(dv * 256 - 1)));
         do_op("rnd", 0, dd, dv, 0, dd / dv, dd % dv, 0, 0, 8);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_approx_restoring_divider
